// File: rtl/status_reg_pkg.sv
// Shared definitions for the 6502 processor status register (P).
// Holds the P bit positions, the commit-control and branch-select encodings,
// the stored-flag record and a helper that builds an 8-bit P image.
package status_reg_pkg;

    // P bit positions
    localparam int FLAG_SHFT_C = 0;
    localparam int FLAG_SHFT_Z = 1;
    localparam int FLAG_SHFT_I = 2;
    localparam int FLAG_SHFT_D = 3;
    localparam int FLAG_SHFT_B = 4;
    localparam int FLAG_SHFT_U = 5;
    localparam int FLAG_SHFT_V = 6;
    localparam int FLAG_SHFT_N = 7;

    // Commit operations; codes 12-15 are unused and behave as NOP.
    typedef enum logic [3:0] {
        PREG_CTRL_NOP      = 4'd0,
        PREG_CTRL_ALU      = 4'd1,
        PREG_CTRL_LOAD     = 4'd2,
        PREG_CTRL_LOAD_RTI = 4'd3,
        PREG_CTRL_CLC      = 4'd4,
        PREG_CTRL_SEC      = 4'd5,
        PREG_CTRL_CLI      = 4'd6,
        PREG_CTRL_SEI      = 4'd7,
        PREG_CTRL_CLV      = 4'd8,
        PREG_CTRL_CLD      = 4'd9,
        PREG_CTRL_SED      = 4'd10,
        PREG_CTRL_IRQ      = 4'd11
    } preg_ctrl_e;

    // Branch flag selector, taken from branch opcode bits [7:6]
    typedef enum logic [1:0] {
        BR_SEL_N = 2'b00,
        BR_SEL_V = 2'b01,
        BR_SEL_C = 2'b10,
        BR_SEL_Z = 2'b11
    } br_sel_e;

    // Only these six flags exist as storage; bits 5 and 4 are synthesised.
    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } flags_t;

    // Build an 8-bit P image; bit 5 is always 1, bit 4 is supplied by caller.
    function automatic logic [7:0] p_image(flags_t f, logic b_bit);
        logic [7:0] p;
        p              = '0;
        p[FLAG_SHFT_N] = f.n;
        p[FLAG_SHFT_V] = f.v;
        p[FLAG_SHFT_U] = 1'b1;
        p[FLAG_SHFT_B] = b_bit;
        p[FLAG_SHFT_D] = f.d;
        p[FLAG_SHFT_I] = f.i;
        p[FLAG_SHFT_Z] = f.z;
        p[FLAG_SHFT_C] = f.c;
        return p;
    endfunction

endpackage

// File: rtl/status_reg_if.sv
// Flag/control bus between the CPU control logic + ALU (master) and the
// status register (slave).
//  en, ctrl, upd_mask   commit strobe, operation, ALU per-bit write enable
//  alu_flag_in          ALU FLAG_OUT being committed
//  din                  data byte for PLP/RTI
//  sync                 instruction-boundary (opcode fetch) cycle
//  push_brk             B bit of the push image (1 = PHP/BRK)
//  br_cond              branch opcode bits [7:5]
//  alu_flag_out         current P, feeds the ALU FLAG_IN
//  dout                 push image of P
//  br_taken             branch condition result
//  irq_mask             I as seen by the interrupt poller
interface status_reg_if;
    import status_reg_pkg::*;

    logic       en;
    logic [3:0] ctrl;
    logic [7:0] upd_mask;
    logic [7:0] alu_flag_in;
    logic [7:0] din;
    logic       sync;
    logic       push_brk;
    logic [2:0] br_cond;
    logic [7:0] alu_flag_out;
    logic [7:0] dout;
    logic       br_taken;
    logic       irq_mask;

    modport master (
        output en, ctrl, upd_mask, alu_flag_in, din, sync, push_brk, br_cond,
        input  alu_flag_out, dout, br_taken, irq_mask
    );

    modport slave (
        input  en, ctrl, upd_mask, alu_flag_in, din, sync, push_brk, br_cond,
        output alu_flag_out, dout, br_taken, irq_mask
    );

endinterface

// File: rtl/status_reg_branch_cond.sv
// Branch condition evaluator (combinational).
//  n, v, c, z   current stored flags
//  br_cond      branch opcode bits [7:5]: [2:1] select flag, [0] required value
//  br_taken     1 when the selected flag equals br_cond[0]
module status_reg_branch_cond
    import status_reg_pkg::*;
(
    input  logic       n,
    input  logic       v,
    input  logic       c,
    input  logic       z,
    input  logic [2:0] br_cond,
    output logic       br_taken
);

    logic flag_sel;

    always_comb begin
        flag_sel = 1'b0;
        case (br_sel_e'(br_cond[2:1]))
            BR_SEL_N: flag_sel = n;
            BR_SEL_V: flag_sel = v;
            BR_SEL_C: flag_sel = c;
            BR_SEL_Z: flag_sel = z;
            default:  flag_sel = 1'b0;
        endcase
    end

    assign br_taken = (flag_sel == br_cond[0]);

endmodule

// File: rtl/status_reg.sv
// 6502 processor status register (P).
// Stores N V D I Z C, commits ALU flags under a per-bit mask, executes the
// flag instructions, PLP/RTI loads and interrupt entry, produces the PHP/BRK
// push image and branch decisions, and keeps the interrupt poller's copy of I
// one instruction boundary behind the architectural I.
//  clk          clock, all state changes on rising edge
//  rst_n        synchronous active-low reset
//  bus          status_reg_if slave modport (see interface for members)
module status_reg
    import status_reg_pkg::*;
#(
    parameter logic [7:0] RESET_P = 8'h24
) (
    input  logic         clk,
    input  logic         rst_n,
    status_reg_if.slave  bus
);

    localparam flags_t RESET_FLAGS = '{
        n: RESET_P[FLAG_SHFT_N],
        v: RESET_P[FLAG_SHFT_V],
        d: RESET_P[FLAG_SHFT_D],
        i: RESET_P[FLAG_SHFT_I],
        z: RESET_P[FLAG_SHFT_Z],
        c: RESET_P[FLAG_SHFT_C]
    };

    flags_t flags_q;
    flags_t flags_d;
    flags_t din_flags;
    flags_t alu_merged;
    logic   irq_mask_q;
    logic   irq_mask_d;

    // Bits 5 and 4 of the mask, ALU flags and data byte have no storage behind
    // them and are deliberately dropped.
    logic   unused_bits;
    assign unused_bits = ^{bus.upd_mask[FLAG_SHFT_U], bus.upd_mask[FLAG_SHFT_B],
                           bus.alu_flag_in[FLAG_SHFT_U], bus.alu_flag_in[FLAG_SHFT_B],
                           bus.din[FLAG_SHFT_U], bus.din[FLAG_SHFT_B]};

    assign din_flags = '{
        n: bus.din[FLAG_SHFT_N],
        v: bus.din[FLAG_SHFT_V],
        d: bus.din[FLAG_SHFT_D],
        i: bus.din[FLAG_SHFT_I],
        z: bus.din[FLAG_SHFT_Z],
        c: bus.din[FLAG_SHFT_C]
    };

    assign alu_merged = '{
        n: bus.upd_mask[FLAG_SHFT_N] ? bus.alu_flag_in[FLAG_SHFT_N] : flags_q.n,
        v: bus.upd_mask[FLAG_SHFT_V] ? bus.alu_flag_in[FLAG_SHFT_V] : flags_q.v,
        d: bus.upd_mask[FLAG_SHFT_D] ? bus.alu_flag_in[FLAG_SHFT_D] : flags_q.d,
        i: bus.upd_mask[FLAG_SHFT_I] ? bus.alu_flag_in[FLAG_SHFT_I] : flags_q.i,
        z: bus.upd_mask[FLAG_SHFT_Z] ? bus.alu_flag_in[FLAG_SHFT_Z] : flags_q.z,
        c: bus.upd_mask[FLAG_SHFT_C] ? bus.alu_flag_in[FLAG_SHFT_C] : flags_q.c
    };

    always_comb begin
        flags_d = flags_q;
        // The poller copy takes the pre-commit I at each instruction boundary,
        // which gives CLI/SEI/PLP their one-instruction latency.
        irq_mask_d = bus.sync ? flags_q.i : irq_mask_q;

        if (bus.en) begin
            case (preg_ctrl_e'(bus.ctrl))
                PREG_CTRL_ALU:  flags_d = alu_merged;
                PREG_CTRL_LOAD: flags_d = din_flags;
                PREG_CTRL_LOAD_RTI: begin
                    flags_d = din_flags;
                    // RTI restores the poller's mask at once, overriding sync.
                    irq_mask_d = bus.din[FLAG_SHFT_I];
                end
                PREG_CTRL_CLC:  flags_d.c = 1'b0;
                PREG_CTRL_SEC:  flags_d.c = 1'b1;
                PREG_CTRL_CLI:  flags_d.i = 1'b0;
                PREG_CTRL_SEI:  flags_d.i = 1'b1;
                PREG_CTRL_CLV:  flags_d.v = 1'b0;
                PREG_CTRL_CLD:  flags_d.d = 1'b0;
                PREG_CTRL_SED:  flags_d.d = 1'b1;
                // NMOS behaviour: interrupt entry leaves D alone.
                PREG_CTRL_IRQ:  flags_d.i = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q    <= RESET_FLAGS;
            irq_mask_q <= 1'b1;
        end else begin
            flags_q    <= flags_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    // ALU always sees bits 5 and 4 as 1.
    assign bus.alu_flag_out = p_image(flags_q, 1'b1);
    assign bus.dout         = p_image(flags_q, bus.push_brk);
    assign bus.irq_mask     = irq_mask_q;

    status_reg_branch_cond u_branch_cond (
        .n        (flags_q.n),
        .v        (flags_q.v),
        .c        (flags_q.c),
        .z        (flags_q.z),
        .br_cond  (bus.br_cond),
        .br_taken (bus.br_taken)
    );

endmodule

// File: tb/tb_status_reg.sv
module tb_status_reg;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Reference model: P as a plain byte (bits 5:4 held at 1) plus poller mask.
    logic [7:0] m_p;
    logic       m_irq;

    status_reg_if bus_if ();

    status_reg #(.RESET_P(8'h24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Branch semantics from the opcode table: 10 BPL, 30 BMI, 50 BVC, 70 BVS,
    // 90 BCC, B0 BCS, D0 BNE, F0 BEQ.
    function automatic logic model_branch(input logic [7:0] p, input logic [2:0] bc);
        case (bc)
            3'd0: return p[7] == 1'b0;
            3'd1: return p[7] == 1'b1;
            3'd2: return p[6] == 1'b0;
            3'd3: return p[6] == 1'b1;
            3'd4: return p[0] == 1'b0;
            3'd5: return p[0] == 1'b1;
            3'd6: return p[1] == 1'b0;
            default: return p[1] == 1'b1;
        endcase
    endfunction

    task automatic check_all(input string tag);
        logic [7:0] exp_dout;
        exp_dout = m_p;
        exp_dout[4] = bus_if.push_brk;
        check({tag, ".p"},    bus_if.alu_flag_out, m_p);
        check({tag, ".dout"}, bus_if.dout, exp_dout);
        check({tag, ".br"},   {7'd0, bus_if.br_taken}, {7'd0, model_branch(m_p, bus_if.br_cond)});
        check({tag, ".irqm"}, {7'd0, bus_if.irq_mask}, {7'd0, m_irq});
    endtask

    // Computes the model's next state from the current inputs, takes one edge,
    // then compares every output.
    task automatic tick(input string tag);
        logic [7:0] np;
        logic       ni;
        np = m_p;
        ni = m_irq;
        if (!rst_n) begin
            np = 8'h34;
            ni = 1'b1;
        end else begin
            if (bus_if.sync) ni = m_p[2];
            if (bus_if.en) begin
                case (bus_if.ctrl)
                    4'd1:  np = (m_p & ~bus_if.upd_mask) | (bus_if.alu_flag_in & bus_if.upd_mask);
                    4'd2:  np = bus_if.din;
                    4'd3:  begin np = bus_if.din; ni = bus_if.din[2]; end
                    4'd4:  np = m_p & 8'hFE;
                    4'd5:  np = m_p | 8'h01;
                    4'd6:  np = m_p & 8'hFB;
                    4'd7:  np = m_p | 8'h04;
                    4'd8:  np = m_p & 8'hBF;
                    4'd9:  np = m_p & 8'hF7;
                    4'd10: np = m_p | 8'h08;
                    4'd11: np = m_p | 8'h04;
                    default: ;
                endcase
            end
            np = np | 8'h30;
        end
        @(posedge clk);
        #1;
        m_p   = np;
        m_irq = ni;
        check_all(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_p    = 8'h34;
        m_irq  = 1'b1;
        rst_n  = 1'b0;
        bus_if.en          = 1'b0;
        bus_if.ctrl        = 4'd0;
        bus_if.upd_mask    = 8'h00;
        bus_if.alu_flag_in = 8'h00;
        bus_if.din         = 8'h00;
        bus_if.sync        = 1'b0;
        bus_if.push_brk    = 1'b1;
        bus_if.br_cond     = 3'd0;

        // Reset
        tick("reset");
        check("reset_p", bus_if.alu_flag_out, 8'h34);
        check("reset_dout_brk", bus_if.dout, 8'h34);
        bus_if.push_brk = 1'b0;
        #1;
        check("reset_dout_irq", bus_if.dout, 8'h24);
        check("reset_irqm", {7'd0, bus_if.irq_mask}, 8'h01);

        // Masked ALU commit, then same with EN low
        rst_n = 1'b1;
        bus_if.en = 1'b1;
        bus_if.ctrl = 4'd1;
        bus_if.upd_mask = 8'hC3;
        bus_if.alu_flag_in = 8'hFF;
        tick("alu_mask");
        check("alu_mask_val", bus_if.alu_flag_out, 8'hF7);
        bus_if.en = 1'b0;
        bus_if.upd_mask = 8'hFF;
        bus_if.alu_flag_in = 8'h00;
        tick("alu_en0");
        check("alu_en0_val", bus_if.alu_flag_out, 8'hF7);

        // PLP / PHP
        bus_if.en = 1'b1;
        bus_if.ctrl = 4'd2;
        bus_if.din = 8'h00;
        tick("plp");
        check("plp_val", bus_if.alu_flag_out, 8'h30);
        bus_if.push_brk = 1'b1;
        #1;
        check("php_brk", bus_if.dout, 8'h30);
        bus_if.push_brk = 1'b0;
        #1;
        check("php_irq", bus_if.dout, 8'h20);

        // CLI delay: establish I=1 and IRQ_MASK=1 first
        bus_if.ctrl = 4'd7;
        bus_if.sync = 1'b1;
        tick("sei");
        bus_if.ctrl = 4'd0;
        tick("sei_sync");
        check("sei_irqm", {7'd0, bus_if.irq_mask}, 8'h01);
        bus_if.ctrl = 4'd6;
        tick("cli_same_sync");
        check("cli_irqm_hold", {7'd0, bus_if.irq_mask}, 8'h01);
        bus_if.ctrl = 4'd0;
        bus_if.sync = 1'b0;
        tick("cli_nosync");
        check("cli_irqm_hold2", {7'd0, bus_if.irq_mask}, 8'h01);
        bus_if.sync = 1'b1;
        tick("cli_next_sync");
        check("cli_irqm_clear", {7'd0, bus_if.irq_mask}, 8'h00);

        // RTI immediacy
        bus_if.ctrl = 4'd7;
        tick("sei2");
        bus_if.ctrl = 4'd0;
        tick("sei2_sync");
        bus_if.ctrl = 4'd3;
        bus_if.din = 8'h00;
        tick("rti");
        check("rti_irqm", {7'd0, bus_if.irq_mask}, 8'h00);
        check("rti_p", bus_if.alu_flag_out, 8'h30);
        bus_if.sync = 1'b0;

        // Branches with P=00 and P=FF
        bus_if.ctrl = 4'd2;
        for (int pv = 0; pv < 2; pv++) begin
            bus_if.din = (pv == 0) ? 8'h00 : 8'hFF;
            tick("br_load");
            for (int bc = 0; bc < 8; bc++) begin
                bus_if.br_cond = 3'(bc);
                #1;
                check("branch", {7'd0, bus_if.br_taken},
                      {7'd0, (bc[0] == (pv == 1))});
            end
        end
        bus_if.din = 8'h02;
        tick("beq_load");
        bus_if.br_cond = 3'b111;
        #1;
        check("beq_z", {7'd0, bus_if.br_taken}, 8'h01);

        // Reset beats a simultaneous SED
        bus_if.ctrl = 4'd10;
        rst_n = 1'b0;
        tick("reset_sed");
        check("reset_sed_p", bus_if.alu_flag_out, 8'h34);
        rst_n = 1'b1;

        // Randomized run against the model
        for (int k = 0; k < 400; k++) begin
            rst_n              = ($urandom_range(0, 63) != 0);
            bus_if.en          = 1'($urandom);
            bus_if.ctrl        = 4'($urandom);
            bus_if.upd_mask    = 8'($urandom);
            bus_if.alu_flag_in = 8'($urandom);
            bus_if.din         = 8'($urandom);
            bus_if.sync        = 1'($urandom);
            bus_if.push_brk    = 1'($urandom);
            bus_if.br_cond     = 3'($urandom);
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
